// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite exclusive-access monitor: one granule reservation per master, failed
// exclusive stores are answered locally and never reach the downstream slave.
module ahbl_excl_monitor #(
    parameter int N_MASTERS = 2,
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int GRAN_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // upstream (arbiter side)
    input  logic              s_hready,
    output logic              s_hready_resp,
    output logic              s_hresp,
    input  logic [W_ADDR-1:0] s_haddr,
    input  logic              s_hwrite,
    input  logic [1:0]        s_htrans,
    input  logic [2:0]        s_hsize,
    input  logic [2:0]        s_hburst,
    input  logic [3:0]        s_hprot,
    input  logic              s_hmastlock,
    input  logic [W_DATA-1:0] s_hwdata,
    output logic [W_DATA-1:0] s_hrdata,
    input  logic              s_hexcl,
    input  logic [7:0]        s_hmaster,
    output logic              s_hexokay,
    // downstream (slave side)
    output logic              m_hready,
    input  logic              m_hready_resp,
    input  logic              m_hresp,
    output logic [W_ADDR-1:0] m_haddr,
    output logic              m_hwrite,
    output logic [1:0]        m_htrans,
    output logic [2:0]        m_hsize,
    output logic [2:0]        m_hburst,
    output logic [3:0]        m_hprot,
    output logic              m_hmastlock,
    output logic [W_DATA-1:0] m_hwdata,
    input  logic [W_DATA-1:0] m_hrdata
);

    localparam int W_GRAN = W_ADDR - GRAN_LOG2;

    logic [N_MASTERS-1:0]             resv_valid;
    logic [N_MASTERS-1:0][W_GRAN-1:0] resv_addr;

    logic                 dph_local;
    logic                 dph_excl;
    logic                 dph_rd;
    logic [7:0]           dph_mast;

    logic [W_GRAN-1:0]    granule;
    logic [N_MASTERS-1:0] match;
    logic                 own_match;
    logic                 id_ok;
    logic                 acc;
    logic                 excl_wr_fail;
    logic                 excl_rd_set;
    logic                 wr_clear;
    logic                 err_clear;

    assign granule = s_haddr[W_ADDR-1:GRAN_LOG2];
    assign id_ok   = int'(s_hmaster) < N_MASTERS;
    assign acc     = s_hready & s_htrans[1];

    always_comb begin
        match     = '0;
        own_match = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            match[k] = resv_valid[k] & (resv_addr[k] == granule);
            if (int'(s_hmaster) == k)
                own_match = match[k];
        end
    end

    assign excl_wr_fail = s_hexcl & s_hwrite & s_htrans[1] & ~(id_ok & own_match);
    assign excl_rd_set  = acc & s_hexcl & ~s_hwrite & id_ok;
    // Any store that actually reaches the slave kills every reservation on its granule
    assign wr_clear     = acc & s_hwrite & ~excl_wr_fail;
    assign err_clear    = dph_excl & dph_rd & m_hresp;

    // Error clear is applied first so a same-cycle set on that master overrides it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid <= '0;
            resv_addr  <= '0;
        end else begin
            for (int k = 0; k < N_MASTERS; k++) begin
                if (err_clear && int'(dph_mast) == k)
                    resv_valid[k] <= 1'b0;
                if (wr_clear && match[k])
                    resv_valid[k] <= 1'b0;
                if (excl_rd_set && int'(s_hmaster) == k) begin
                    resv_valid[k] <= 1'b1;
                    resv_addr[k]  <= granule;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_local <= 1'b0;
            dph_excl  <= 1'b0;
            dph_rd    <= 1'b0;
            dph_mast  <= '0;
        end else if (s_hready) begin
            dph_local <= acc & excl_wr_fail;
            dph_excl  <= acc & s_hexcl & id_ok;
            dph_rd    <= ~s_hwrite;
            dph_mast  <= s_hmaster;
        end
    end

    // Address phase: only htrans is touched, and only to squash a failing store
    assign m_haddr     = s_haddr;
    assign m_hwrite    = s_hwrite;
    assign m_htrans    = excl_wr_fail ? 2'b00 : s_htrans;
    assign m_hsize     = s_hsize;
    assign m_hburst    = s_hburst;
    assign m_hprot     = s_hprot;
    assign m_hmastlock = s_hmastlock;
    assign m_hready    = s_hready;
    assign m_hwdata    = s_hwdata;

    assign s_hready_resp = dph_local ? 1'b1   : m_hready_resp;
    assign s_hresp       = dph_local ? 1'b0   : m_hresp;
    assign s_hrdata      = dph_local ? '0     : m_hrdata;
    assign s_hexokay     = dph_excl & ~dph_local & ~m_hresp;

endmodule
